bch_determinant: RTL and testbench



---
 rtl/bch_determinant.sv | 158 +++++++++++++++
 tb/tb_bch_determinant.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bch_determinant.sv
// Determinant of the order-1..3 syndrome matrix over GF(2^M) by row-0 cofactor
// expansion, using one bit-serial GF multiplier and an XOR accumulator.
module bch_determinant #(
    parameter int unsigned M    = 6,
    parameter logic [M:0]  POLY = 7'b1000011
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_det,
    input  logic [4:0]                size,
    input  logic [3:0][3:0][M-1:0]    first_matrix,
    input  logic [3:0][3:0][M-1:0]    minor_matrix,
    output logic [M-1:0]              det_out,
    output logic                      singular,
    output logic                      size_err,
    output logic                      finished_det
);

    localparam int unsigned KW   = $clog2(M);
    localparam int unsigned NCOL = 3;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t                     state_q, state_d;
    logic [NCOL-1:0][M-1:0]     a_q, a_d;
    logic [NCOL-1:0][M-1:0]     b_q, b_d;
    logic [1:0]                 n_q, n_d;
    logic [1:0]                 j_q, j_d;
    logic [KW-1:0]              k_q, k_d;
    logic [M-1:0]               p_q, p_d;
    logic [M-1:0]               acc_q, acc_d;
    logic [M-1:0]               det_d;
    logic                       singular_d;
    logic                       size_err_d;
    logic                       finished_d;
    logic [M-1:0]               sum_c;

    // Multiply by x with reduction modulo POLY.
    function automatic logic [M-1:0] xtime(input logic [M-1:0] x);
        return {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY[M-1:0] : '0);
    endfunction

    assign sum_c = acc_q ^ p_q;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        n_d        = n_q;
        j_d        = j_q;
        k_d        = k_q;
        p_d        = p_q;
        acc_d      = acc_q;
        det_d      = det_out;
        singular_d = singular;
        size_err_d = size_err;
        finished_d = finished_det;

        case (state_q)
            IDLE: begin
                if (start_det && !finished_det) begin
                    for (int c = 0; c < NCOL; c++) begin
                        a_d[c] = first_matrix[0][c];
                        b_d[c] = minor_matrix[0][c];
                    end
                    acc_d = '0;
                    p_d   = '0;
                    j_d   = '0;
                    k_d   = KW'(M - 1);
                    if (size == 5'd1) begin
                        // Order 1: the lone cofactor is the empty minor, i.e. 1.
                        b_d[0]  = M'(1);
                        n_d     = 2'd1;
                        state_d = MUL;
                    end else if (size == 5'd2 || size == 5'd3) begin
                        n_d     = size[1:0];
                        state_d = MUL;
                    end else begin
                        det_d      = '0;
                        size_err_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            MUL: begin
                if (!start_det) begin
                    state_d = IDLE;
                end else begin
                    // MSB-first shift-and-add over the bits of b_j.
                    p_d = xtime(p_q) ^ (b_q[j_q][k_q] ? a_q[j_q] : '0);
                    if (k_q == '0) begin
                        state_d = ACC;
                    end else begin
                        k_d = k_q - KW'(1);
                    end
                end
            end
            ACC: begin
                if (!start_det) begin
                    state_d = IDLE;
                end else begin
                    acc_d = sum_c;
                    p_d   = '0;
                    k_d   = KW'(M - 1);
                    if (j_q == n_q - 2'd1) begin
                        det_d      = sum_c;
                        singular_d = (sum_c == '0);
                        size_err_d = 1'b0;
                        state_d    = DONE;
                    end else begin
                        j_d     = j_q + 2'd1;
                        state_d = MUL;
                    end
                end
            end
            DONE: begin
                if (!start_det) begin
                    finished_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    finished_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            n_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            p_q          <= '0;
            acc_q        <= '0;
            det_out      <= '0;
            singular     <= 1'b0;
            size_err     <= 1'b0;
            finished_det <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            n_q          <= n_d;
            j_q          <= j_d;
            k_q          <= k_d;
            p_q          <= p_d;
            acc_q        <= acc_d;
            det_out      <= det_d;
            singular     <= singular_d;
            size_err     <= size_err_d;
            finished_det <= finished_d;
        end
    end

endmodule

// File: tb/tb_bch_determinant.sv
// Bench for bch_determinant: directed vectors, randomized requests against a
// polynomial-arithmetic reference, size errors, abort, hold and reset.
`timescale 1ns/1ps
module tb_bch_determinant;

    localparam int unsigned M    = 6;
    localparam logic [M:0]  POLY = 7'b1000011;
    localparam int          MAXWAIT = 80;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start_det;
    logic [4:0]             size;
    logic [3:0][3:0][M-1:0] fm, mm;
    logic [M-1:0]           det_out;
    logic                   singular, size_err, finished_det;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bch_determinant #(.M(M), .POLY(POLY)) dut (
        .clk(clk), .rst(rst), .start_det(start_det), .size(size),
        .first_matrix(fm), .minor_matrix(mm),
        .det_out(det_out), .singular(singular), .size_err(size_err),
        .finished_det(finished_det)
    );

    // Carry-less full product followed by long division by POLY.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] prod = '0;
        for (int i = 0; i < M; i++)
            if (b[i]) prod ^= (2*M-1)'(a) << i;
        for (int i = 2*M-2; i >= int'(M); i--)
            if (prod[i]) prod ^= (2*M-1)'(POLY) << (i - M);
        return prod[M-1:0];
    endfunction

    function automatic logic [M-1:0] model_det(input int n, input logic [2:0][M-1:0] a,
                                               input logic [2:0][M-1:0] b);
        logic [M-1:0] d = '0;
        for (int j = 0; j < n; j++)
            d ^= gf_mul(a[j], (n == 1) ? M'(1) : b[j]);
        return d;
    endfunction

    function automatic int exp_lat(input int n);
        return (n >= 1 && n <= 3) ? 1 + n * (M + 1) : 1;
    endfunction

    // Present a request; edge 0 is the next rising edge.
    task automatic launch(input int n, input logic [2:0][M-1:0] a, input logic [2:0][M-1:0] b);
        @(negedge clk);
        size = 5'(n);
        fm   = {$urandom, $urandom, $urandom};
        mm   = {$urandom, $urandom, $urandom};
        for (int j = 0; j < 3; j++) begin
            fm[0][j] = a[j];
            mm[0][j] = b[j];
        end
        start_det = 1'b1;
    endtask

    // Edge index after which finished_det is first seen, -1 on timeout.
    // Inputs are scrambled after edge 0 to show they are no longer sampled.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int e = 0; e < MAXWAIT; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                fm   = {$urandom, $urandom, $urandom};
                mm   = {$urandom, $urandom, $urandom};
                size = 5'($urandom);
            end
            if (finished_det) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic drop_start;
        @(negedge clk);
        start_det = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_check(input string name, input int n, input logic [2:0][M-1:0] a,
                             input logic [2:0][M-1:0] b);
        int lat;
        logic [M-1:0] exp_d;
        exp_d = (n >= 1 && n <= 3) ? model_det(n, a, b) : '0;
        launch(n, a, b);
        wait_done(lat);
        tests_run++;
        if (lat !== exp_lat(n)) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat(n));
        end
        tests_run++;
        if (det_out !== exp_d) begin
            tests_failed++;
            $display("FAIL %s det_out: got %0d want %0d", name, det_out, exp_d);
        end
        tests_run++;
        if (size_err !== !(n >= 1 && n <= 3)) begin
            tests_failed++;
            $display("FAIL %s size_err: got %0b want %0b", name, size_err, !(n >= 1 && n <= 3));
        end
        if (n >= 1 && n <= 3) begin
            tests_run++;
            if (singular !== (exp_d == '0)) begin
                tests_failed++;
                $display("FAIL %s singular: got %0b want %0b", name, singular, exp_d == '0);
            end
        end
        drop_start();
        tests_run++;
        if (finished_det !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s finished_det after drop: got %0b want 0", name, finished_det);
        end
    endtask

    task automatic test_reset;
        tests_run++;
        if ({det_out, singular, size_err, finished_det} !== '0) begin
            tests_failed++;
            $display("FAIL reset outputs: got det=%0d sg=%0b se=%0b fin=%0b want all 0",
                     det_out, singular, size_err, finished_det);
        end
    endtask

    task automatic test_directed;
        run_check("mul_basic", 2, {6'd0, 6'd1, 6'd2},  {6'd0, 6'd1, 6'd32});
        run_check("reduction", 2, {6'd0, 6'd0, 6'd32}, {6'd0, 6'd7, 6'd32});
        run_check("identity3", 3, {6'd0, 6'd0, 6'd1},  {6'd0, 6'd0, 6'd1});
        run_check("singular2", 2, {6'd0, 6'd1, 6'd1},  {6'd0, 6'd1, 6'd1});
        run_check("size1",     1, {6'd9, 6'd3, 6'd5},  {6'd7, 6'd0, 6'd0});
    endtask

    task automatic test_size_err;
        run_check("size4", 4, {6'd1, 6'd2, 6'd3}, {6'd4, 6'd5, 6'd6});
        run_check("size0", 0, {6'd1, 6'd2, 6'd3}, {6'd4, 6'd5, 6'd6});
        run_check("clear_err", 1, {6'd0, 6'd0, 6'd33}, {6'd0, 6'd0, 6'd0});
    endtask

    task automatic test_random;
        logic [2:0][M-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = 18'($urandom);
            b = 18'($urandom);
            if (i % 6 == 5) b = a;
            run_check("random", int'($urandom_range(1, 3)), a, b);
        end
    endtask

    task automatic test_hold;
        int lat;
        logic [M-1:0] held;
        logic ok = 1'b1;
        launch(3, {6'd17, 6'd40, 6'd63}, {6'd5, 6'd12, 6'd33});
        wait_done(lat);
        held = det_out;
        for (int c = 0; c < 3 * exp_lat(3); c++) begin
            @(posedge clk); #1;
            if (!finished_det || det_out !== held) ok = 1'b0;
        end
        tests_run++;
        if (!ok || held !== model_det(3, {6'd17, 6'd40, 6'd63}, {6'd5, 6'd12, 6'd33})) begin
            tests_failed++;
            $display("FAIL hold_start: stable=%0b det=%0d want %0d", ok, held,
                     model_det(3, {6'd17, 6'd40, 6'd63}, {6'd5, 6'd12, 6'd33}));
        end
        drop_start();
    endtask

    task automatic test_abort;
        logic seen = 1'b0;
        run_check("pre_abort", 2, {6'd0, 6'd5, 6'd3}, {6'd0, 6'd9, 6'd11});
        launch(3, {6'd1, 6'd2, 6'd3}, {6'd4, 6'd5, 6'd6});
        repeat (4) @(posedge clk);
        @(negedge clk);
        start_det = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (finished_det) seen = 1'b1;
        end
        tests_run++;
        if (seen || det_out !== model_det(2, {6'd0, 6'd5, 6'd3}, {6'd0, 6'd9, 6'd11})) begin
            tests_failed++;
            $display("FAIL abort: finished_seen=%0b det=%0d want 0 and %0d", seen, det_out,
                     model_det(2, {6'd0, 6'd5, 6'd3}, {6'd0, 6'd9, 6'd11}));
        end
        run_check("post_abort", 3, {6'd10, 6'd20, 6'd30}, {6'd1, 6'd2, 6'd3});
    endtask

    task automatic test_rst_mid;
        run_check("pre_rst", 1, {6'd0, 6'd0, 6'd44}, {6'd0, 6'd0, 6'd0});
        launch(3, {6'd7, 6'd8, 6'd9}, {6'd3, 6'd2, 6'd1});
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({det_out, singular, size_err, finished_det} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid outputs: got det=%0d sg=%0b se=%0b fin=%0b want all 0",
                     det_out, singular, size_err, finished_det);
        end
        @(negedge clk);
        rst = 1'b0;
        start_det = 1'b0;
        run_check("post_rst", 3, {6'd7, 6'd8, 6'd9}, {6'd3, 6'd2, 6'd1});
    endtask

    initial begin
        rst = 1'b1;
        start_det = 1'b0;
        size = '0;
        fm = '0;
        mm = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_directed();
        test_size_err();
        test_random();
        test_hold();
        test_abort();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
